// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: steps the DG408 mux through the enabled channels,
// runs one SPI ADC conversion per channel and keeps the 12-bit results
// in a per-channel bank that the MCU reads through the register bus.
module adc_scan_sequencer #(
  parameter int NUM_CHANNELS  = 8,
  parameter int SETTLE_CYCLES = 50,
  parameter int ADC_INPUT     = 0
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] data_in,
  input  logic        ctrl_load,
  input  logic        sel_load,
  output logic [15:0] status_out,
  output logic [15:0] result_out,
  output logic [15:0] spi_mo_data,
  output logic        spi_mo_load,
  input  logic        spi_busy,
  input  logic [15:0] spi_mi_data,
  output logic [3:0]  anmux_ctrl,
  output logic        scan_done
);

  localparam logic [7:0]  VALID_MASK  = 8'((9'd1 << NUM_CHANNELS) - 9'd1);
  localparam logic [9:0]  SETTLE_LOAD = 10'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SPI_CMD     = 16'((ADC_INPUT & 7) << 11);

  typedef enum logic [2:0] {
    IDLE, MUX_SET, SETTLE, ISSUE, WAIT_START, WAIT_DONE, STORE, NEXT
  } state_t;

  state_t      state, state_next;
  logic [2:0]  ch, ch_next;
  logic [9:0]  settle_cnt;
  logic        run, oneshot, done, overrun;
  logic [7:0]  mask;
  logic [2:0]  sel;
  logic [11:0] bank [8];

  logic        active;
  logic        any_enabled;
  logic [2:0]  low_ch;
  logic        higher_found;
  logic [2:0]  higher_ch;

  // Bits of the bus words this block has no use for.
  logic unused_bits;
  assign unused_bits = &{1'b0, data_in[7:3], spi_mi_data[15:12]};

  assign active      = run | oneshot;
  assign any_enabled = |mask;

  // Find the lowest enabled channel and the next enabled channel above ch.
  always_comb begin
    low_ch       = 3'd0;
    higher_ch    = 3'd0;
    higher_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) low_ch = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (mask[i] && (i > int'(ch)) && !higher_found) begin
        higher_found = 1'b1;
        higher_ch    = 3'(i);
      end
    end
  end

  // Next-state logic; an abort only takes effect outside the SPI transfer.
  always_comb begin
    state_next = state;
    ch_next    = ch;
    scan_done  = 1'b0;
    case (state)
      IDLE: begin
        if (active && any_enabled) begin
          state_next = MUX_SET;
          ch_next    = low_ch;
        end
      end
      MUX_SET:    state_next = active ? SETTLE : IDLE;
      SETTLE: begin
        if (!active)              state_next = IDLE;
        else if (settle_cnt == 0) state_next = ISSUE;
      end
      ISSUE:      state_next = WAIT_START;
      WAIT_START: if (spi_busy)  state_next = WAIT_DONE;
      WAIT_DONE:  if (!spi_busy) state_next = STORE;
      STORE:      state_next = active ? NEXT : IDLE;
      NEXT: begin
        if (!active) begin
          state_next = IDLE;
        end else if (higher_found) begin
          state_next = MUX_SET;
          ch_next    = higher_ch;
        end else begin
          scan_done = 1'b1;
          if (run && any_enabled) begin
            state_next = MUX_SET;
            ch_next    = low_ch;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default:    state_next = IDLE;
    endcase
    if (state_next == IDLE) ch_next = 3'd0;
  end

  // State and channel registers.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state <= IDLE;
      ch    <= 3'd0;
    end else begin
      state <= state_next;
      ch    <= ch_next;
    end
  end

  // Settle counter: loaded in MUX_SET so SETTLE lasts SETTLE_CYCLES cycles.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      settle_cnt <= 10'd0;
    end else if (state == MUX_SET) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state == SETTLE && settle_cnt != 0) begin
      settle_cnt <= settle_cnt - 10'd1;
    end
  end

  // Control word, sticky flags and result select; a flag set beats a clear.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      run     <= 1'b0;
      oneshot <= 1'b0;
      mask    <= 8'h00;
      done    <= 1'b0;
      overrun <= 1'b0;
      sel     <= 3'd0;
    end else begin
      if (scan_done && !run) oneshot <= 1'b0;
      if (ctrl_load) begin
        run     <= data_in[0];
        oneshot <= data_in[1];
        mask    <= data_in[15:8] & VALID_MASK;
        if (data_in[2]) begin
          done    <= 1'b0;
          overrun <= 1'b0;
        end
      end
      if (scan_done) begin
        done <= 1'b1;
        if (done) overrun <= 1'b1;
      end
      if (sel_load) sel <= data_in[2:0];
    end
  end

  // Result bank written once per conversion in STORE.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      for (int i = 0; i < 8; i++) bank[i] <= 12'h000;
    end else if (state == STORE) begin
      bank[ch] <= spi_mi_data[11:0];
    end
  end

  assign spi_mo_data = SPI_CMD;
  assign spi_mo_load = (state == ISSUE);
  assign anmux_ctrl  = (state == IDLE) ? 4'b0000 : {1'b1, ch};
  assign result_out  = (int'(sel) < NUM_CHANNELS) ? {4'h0, bank[sel]} : 16'h0000;
  // done/overrun show the flag being set in the NEXT cycle itself.
  assign status_out  = {mask, 1'b0, ch, run,
                        overrun | (scan_done & done),
                        done | scan_done,
                        state != IDLE};

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed checks of the scan sequencer with a
// simple SPI responder returning 16'hF000 | ch*16'h111.
module tb_adc_scan_sequencer;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic        ctrl_load = 1'b0;
  logic        sel_load = 1'b0;
  logic [15:0] status_out, result_out, spi_mo_data, spi_mi_data;
  logic        spi_mo_load, spi_busy, scan_done;
  logic [3:0]  anmux_ctrl;

  int errors = 0;
  int checks = 0;
  int load_count = 0;
  int done_count = 0;
  int bad_data = 0;
  int spi_len = 3;
  int spi_cnt = 0;
  logic [3:0] load_mux [64];
  int base_loads, base_dones;

  adc_scan_sequencer #(.NUM_CHANNELS(8), .SETTLE_CYCLES(4), .ADC_INPUT(0)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .data_in(data_in),
    .ctrl_load(ctrl_load), .sel_load(sel_load), .status_out(status_out),
    .result_out(result_out), .spi_mo_data(spi_mo_data),
    .spi_mo_load(spi_mo_load), .spi_busy(spi_busy),
    .spi_mi_data(spi_mi_data), .anmux_ctrl(anmux_ctrl), .scan_done(scan_done)
  );

  always #5 sysclk = ~sysclk;

  // SPI master model: busy the cycle after the load, for spi_len+1 cycles.
  always @(posedge sysclk) begin
    if (sysreset) begin
      spi_busy    <= 1'b0;
      spi_cnt     <= 0;
      spi_mi_data <= 16'h0;
    end else if (spi_mo_load) begin
      spi_busy    <= 1'b1;
      spi_cnt     <= spi_len;
      spi_mi_data <= 16'hF000 | (16'(anmux_ctrl[2:0]) * 16'h0111);
    end else if (spi_cnt != 0) begin
      spi_cnt <= spi_cnt - 1;
    end else begin
      spi_busy <= 1'b0;
    end
  end

  // Event monitor: SPI loads, their mux setting and scan_done pulses.
  always @(posedge sysclk) begin
    if (spi_mo_load === 1'b1) begin
      if (load_count < 64) load_mux[load_count] <= anmux_ctrl;
      if (spi_mo_data !== 16'h0000) bad_data <= bad_data + 1;
      load_count <= load_count + 1;
    end
    if (scan_done === 1'b1) done_count <= done_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    @(negedge sysclk);
    data_in   = word;
    ctrl_load = 1'b1;
    @(negedge sysclk);
    ctrl_load = 1'b0;
  endtask

  task automatic readResult(input int k, input logic [15:0] expected);
    @(negedge sysclk);
    data_in  = 16'(k);
    sel_load = 1'b1;
    @(negedge sysclk);
    sel_load = 1'b0;
    checkOutput($sformatf("bank%0d", k), 32'(result_out), 32'(expected));
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    @(negedge sysclk);
    while (status_out[0] === 1'b1 && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({tag, "_timeout"}, 32'(status_out[0]), 32'd0);
  endtask

  task automatic doReset();
    @(negedge sysclk);
    sysreset = 1'b1;
    repeat (2) @(negedge sysclk);
    sysreset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge sysclk);
    checkOutput("rst_status", 32'(status_out), 32'h0);
    checkOutput("rst_anmux", 32'(anmux_ctrl), 32'h0);
    checkOutput("rst_load", 32'(spi_mo_load), 32'h0);
    checkOutput("rst_done", 32'(scan_done), 32'h0);
    checkOutput("rst_result", 32'(result_out), 32'h0);
    sysreset = 1'b0;

    // Oneshot full scan, mask FF
    applyStimulus(16'hFF02);
    waitIdle("full", 1000);
    checkOutput("full_loads", 32'(load_count), 32'd8);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("full_mux%0d", k), 32'(load_mux[k]), 32'(8 + k));
    checkOutput("full_cmd", 32'(bad_data), 32'd0);
    checkOutput("full_dones", 32'(done_count), 32'd1);
    checkOutput("full_status", 32'(status_out), 32'hFF02);
    checkOutput("full_anmux", 32'(anmux_ctrl), 32'h0);
    for (int k = 0; k < 8; k++) readResult(k, 16'((k * 16'h111) & 16'h0FFF));

    // Sparse mask 8'b10100100
    doReset();
    base_loads = load_count;
    applyStimulus(16'hA402);
    waitIdle("sparse", 1000);
    checkOutput("sparse_loads", 32'(load_count - base_loads), 32'd3);
    checkOutput("sparse_status", 32'(status_out), 32'hA402);
    readResult(0, 16'h000);
    readResult(1, 16'h000);
    readResult(2, 16'h222);
    readResult(3, 16'h000);
    readResult(4, 16'h000);
    readResult(5, 16'h555);
    readResult(6, 16'h000);
    readResult(7, 16'h777);

    // Continuous run, mask 01: second scan sets overrun, then clear it
    doReset();
    base_dones = done_count;
    applyStimulus(16'h0101);
    begin
      int n = 0;
      while ((done_count - base_dones) < 2 && n < 500) begin
        @(negedge sysclk);
        n++;
      end
    end
    checkOutput("run_two_scans", 32'((done_count - base_dones) >= 2), 32'd1);
    checkOutput("run_flags", 32'(status_out[2:1]), 32'h3);
    applyStimulus(16'h0105);
    checkOutput("run_cleared", 32'(status_out[2:1]), 32'h0);
    checkOutput("run_bit", 32'(status_out[3]), 32'h1);
    checkOutput("run_busy", 32'(status_out[0]), 32'h1);
    applyStimulus(16'h0100);
    waitIdle("run_stop", 200);

    // Abort during WAIT_DONE on channel 3
    doReset();
    spi_len = 40;
    base_loads = load_count;
    base_dones = done_count;
    applyStimulus(16'h0802);
    begin
      int n = 0;
      while (spi_busy !== 1'b1 && n < 200) begin
        @(negedge sysclk);
        n++;
      end
    end
    repeat (3) @(negedge sysclk);
    checkOutput("abort_anmux_busy", 32'(anmux_ctrl), 32'hB);
    applyStimulus(16'h0000);
    checkOutput("abort_still_busy", 32'(status_out[0]), 32'h1);
    waitIdle("abort", 200);
    checkOutput("abort_anmux", 32'(anmux_ctrl), 32'h0);
    checkOutput("abort_dones", 32'(done_count - base_dones), 32'd0);
    checkOutput("abort_loads", 32'(load_count - base_loads), 32'd1);
    checkOutput("abort_status", 32'(status_out), 32'h0000);
    readResult(3, 16'h333);
    spi_len = 3;

    // Reset while in SETTLE
    doReset();
    base_loads = load_count;
    applyStimulus(16'h0102);
    repeat (2) @(negedge sysclk);
    checkOutput("settle_anmux", 32'(anmux_ctrl), 32'h8);
    sysreset = 1'b1;
    @(negedge sysclk);
    checkOutput("srst_anmux", 32'(anmux_ctrl), 32'h0);
    checkOutput("srst_status", 32'(status_out), 32'h0);
    @(negedge sysclk);
    sysreset = 1'b0;
    repeat (20) @(negedge sysclk);
    checkOutput("srst_loads", 32'(load_count - base_loads), 32'd0);

    // Start with mask 0: nothing happens
    base_loads = load_count;
    applyStimulus(16'h0001);
    begin
      int seen_busy = 0;
      for (int n = 0; n < 1000; n++) begin
        @(negedge sysclk);
        if (status_out[0] !== 1'b0 || spi_mo_load !== 1'b0) seen_busy++;
      end
      checkOutput("mask0_activity", 32'(seen_busy), 32'd0);
    end
    checkOutput("mask0_loads", 32'(load_count - base_loads), 32'd0);
    checkOutput("mask0_status", 32'(status_out), 32'h0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Hardware scan controller for the DE0-nano analog front end. It owns the DG408 analog mux control lines and the SPI ADC master, and steps through an enabled set of mux channels. For each channel it sets the mux, waits a settle time and runs one SPI conversion, then stores the 12-bit result in a per-channel result bank. The MCU configures it and reads results through two load strobes and two read registers on the register bus. A scan-done pulse feeds the event controller.

## Interface
- NUM_CHANNELS, 8: mux channels scanned (1..8); channel index is 3 bits.
- SETTLE_CYCLES, 50: sysclk cycles between mux change and SPI start (1..1023).
- ADC_INPUT, 0: ADC input number placed in the SPI command word, bits 13:11.

Ports:
- sysclk  in  1  system clock.
- sysreset  in  1  synchronous, active-high reset.
- data_in  in  16  register-bus load data (r_load_data).
- ctrl_load  in  1  load control word from data_in.
- sel_load  in  1  load result select from data_in[2:0].
- status_out  out  16  status register.
- result_out  out  16  result bank entry addressed by result select.
- spi_mo_data  out  16  SPI command word = ADC_INPUT << 11, constant.
- spi_mo_load  out  1  one-cycle SPI start strobe.
- spi_busy  in  1  SPI master busy.
- spi_mi_data  in  16  SPI received word.
- anmux_ctrl  out  4  {en, a2, a1, a0} to the DG408.
- scan_done  out  1  one-cycle pulse at the end of each completed scan.

## Operation
- Control word (ctrl_load):
  - bit0 run: continuous scanning.
  - bit1 oneshot: one scan.
  - bit2 clear_flags: clears done and overrun.
  - bits 15:8 channel mask: bit k enables channel k. Bits at or above NUM_CHANNELS are ignored.
- Status word:
  - bit0 busy: not IDLE.
  - bit1 done: sticky.
  - bit2 overrun: sticky.
  - bit3 run.
  - bits 6:4 current channel.
  - bits 15:8 mask.
  - All other bits are 0.
- result_out = {4'h0, bank[sel][11:0]}. The bank is combinationally read. A sel value at or above NUM_CHANNELS reads 0.
- FSM states: IDLE, MUX_SET, SETTLE, ISSUE, WAIT_START, WAIT_DONE, STORE, NEXT.
- IDLE -> MUX_SET on (run or oneshot) with a non-zero effective mask. The channel starts at the lowest enabled index. With mask 0, stay IDLE and set no flags.
- MUX_SET: drive anmux_ctrl = {1, ch}; load the settle counter; go to SETTLE.
- SETTLE: count down SETTLE_CYCLES, then go to ISSUE.
- ISSUE: spi_mo_load = 1 for exactly one cycle; go to WAIT_START.
- WAIT_START: wait for spi_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for spi_busy = 0, then go to STORE.
- STORE: bank[ch] <= spi_mi_data & 16'h0FFF.
- NEXT:
  - If a higher enabled channel exists, advance ch to it and go to MUX_SET.
  - Otherwise the scan is complete. Pulse scan_done and set done. If done was already 1, also set overrun.
  - After a completed scan: if run = 1, restart at the lowest enabled channel (MUX_SET). If run = 0, clear oneshot and go to IDLE.
- Abort: a ctrl write with run = 0 and oneshot = 0 during a scan never cuts an SPI transfer.
  - In MUX_SET or SETTLE: go to IDLE on the next cycle.
  - In ISSUE, WAIT_START or WAIT_DONE: finish through STORE, then go to IDLE.
  - An aborted scan produces no scan_done and sets no done.
- A mask written mid-scan takes effect at the next channel selection. If no higher channel remains enabled, the scan completes at NEXT.
- A clear_flags write in the same cycle as a done set: the set wins.
- anmux_ctrl en = 0 in IDLE; en = 1 in all other states.

## Timing
- Reset values:
  - FSM is IDLE.
  - anmux_ctrl = 4'b0000, spi_mo_load = 0, scan_done = 0.
  - status_out = 16'h0000; run, oneshot and mask are 0.
  - Bank entries and result select are 0.
- Reset is synchronous and overrides everything, including mid-transfer. The SPI master is reset by the same sysreset.
- ctrl_load is registered. The FSM leaves IDLE on the cycle after the load.
- Per-channel latency: 1 (MUX_SET) + SETTLE_CYCLES + 1 (ISSUE) + SPI transfer + 1 (STORE) + 1 (NEXT).
- The bank entry is valid on the cycle after STORE. scan_done is asserted in NEXT together with done = 1 in status_out.
- If spi_busy never rises, WAIT_START holds indefinitely; the SPI master guarantees busy within 2 cycles of the load.

## Test plan
- Oneshot, SPI model returns 16'hF000 | (ch*16'h111), mask 8'hFF, SETTLE_CYCLES 4:
  - anmux_ctrl steps 8 to 15; eight spi_mo_load pulses, each with spi_mo_data = 16'h0000.
  - bank[k] = (k*16'h111) & 16'h0FFF; exactly one scan_done; status returns to 16'hFF02.
- Mask 8'b10100100 oneshot: only channels 2, 5 and 7 are converted; other bank entries stay 0.
- Run with mask 8'h01, no flag clear: the second completed scan sets overrun (status bit2). Writing clear_flags with run still set clears bits 1 and 2.
- Abort mid-WAIT_DONE on channel 3: the transfer completes, bank[3] is updated, the FSM goes IDLE with anmux_ctrl 0, and no scan_done.
- sysreset asserted in SETTLE: next cycle anmux_ctrl = 0, status_out = 0, no spi_mo_load issued.
- Start with mask 0: remains IDLE, status busy = 0, no SPI activity for 1000 cycles.
